// File: rtl/easy6502_pkg.sv
// Shared definitions for the easy6502 system: RAM geometry, the fixed pad
// byte location and the RAM arbiter state encoding.
package easy6502_pkg;

  localparam int RAM_ADDR_W = 11;
  localparam int RAM_DATA_W = 8;

  // Software reads the latest pad byte from this RAM location.
  localparam logic [RAM_ADDR_W-1:0] PAD_RAM_ADDR = 11'd10;

  typedef enum logic [1:0] {
    ARB_RUN    = 2'd0,
    ARB_HOLD   = 2'd1,
    ARB_RESUME = 2'd2
  } arb_state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of every requester and RAM-side signal around the RAM arbiter.
// slave: the arbiter itself; master: the surrounding system (CPU, VGA,
// loader, pad and the RAM).
interface ram_arbiter_if
  import easy6502_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_W,
  parameter int DATA_WIDTH = RAM_DATA_W
) ();

  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_we;
  logic                  cpu_rdy;

  logic                  vga_req;
  logic [ADDR_WIDTH-1:0] vga_addr;
  logic                  vga_gnt;

  logic                  uart_req;
  logic                  uart_we;
  logic [ADDR_WIDTH-1:0] uart_addr;
  logic [DATA_WIDTH-1:0] uart_wdata;

  logic                  periph_strobe;
  logic [DATA_WIDTH-1:0] periph_wdata;
  logic                  periph_pending;

  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_we;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_we,
    input  vga_req, vga_addr,
    input  uart_req, uart_we, uart_addr, uart_wdata,
    input  periph_strobe, periph_wdata,
    output cpu_rdy, vga_gnt, periph_pending,
    output ram_raddr, ram_waddr, ram_wdata, ram_we
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_we,
    output vga_req, vga_addr,
    output uart_req, uart_we, uart_addr, uart_wdata,
    output periph_strobe, periph_wdata,
    input  cpu_rdy, vga_gnt, periph_pending,
    input  ram_raddr, ram_waddr, ram_wdata, ram_we
  );

endinterface

// File: rtl/periph_latch.sv
// Holds the most recent pad byte until the arbiter has written it to RAM.
// A new strobe always wins over a clear in the same cycle, so a byte that
// arrives while the previous one is being written is never lost.
module periph_latch #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  strobe,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  clear,
  output logic                  pending,
  output logic [DATA_WIDTH-1:0] data
);

  // Capture the byte on strobe; drop the pending flag once it is written.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
      data    <= '0;
    end else if (strobe) begin
      pending <= 1'b1;
      data    <= wdata;
    end else if (clear) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the system RAM between the 6502, VGA screen reads, the UART loader
// and the pad byte, stalling the CPU through RDY while anyone else needs it.
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   ARB_RUN    | CPU owns both RAM ports, RDY high
//   ARB_HOLD   | CPU stalled; VGA reads, loader / pad writes are served
//   ARB_RESUME | CPU still stalled; its last read address is re-presented
//              | so DI holds the right byte on the first resumed cycle
module ram_arbiter
  import easy6502_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = RAM_ADDR_W,
  parameter int                    DATA_WIDTH  = RAM_DATA_W,
  parameter logic [ADDR_WIDTH-1:0] PERIPH_ADDR = ADDR_WIDTH'(PAD_RAM_ADDR)
) (
  input logic          clk,
  input logic          reset,
  ram_arbiter_if.slave bus
);

  arb_state_t            state;
  logic                  cpu_rdy_q;
  logic [ADDR_WIDTH-1:0] cpu_addr_last;

  logic                  pad_pending;
  logic [DATA_WIDTH-1:0] pad_data;
  logic                  pad_write;
  logic                  busy;

  assign busy = bus.vga_req | bus.uart_req | pad_pending;

  periph_latch #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_periph_latch (
    .clk    (clk),
    .reset  (reset),
    .strobe (bus.periph_strobe),
    .wdata  (bus.periph_wdata),
    .clear  (pad_write),
    .pending(pad_pending),
    .data   (pad_data)
  );

  // Ownership FSM; RDY is registered alongside the state so it only rises
  // on entry to RUN and falls on the first HOLD cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ARB_HOLD;
      cpu_rdy_q     <= 1'b0;
      cpu_addr_last <= '0;
    end else begin
      unique case (state)
        ARB_RUN: begin
          cpu_addr_last <= bus.cpu_addr;
          if (busy) begin
            state     <= ARB_HOLD;
            cpu_rdy_q <= 1'b0;
          end
        end
        ARB_HOLD: begin
          if (!busy) state <= ARB_RESUME;
        end
        ARB_RESUME: begin
          if (busy) begin
            state <= ARB_HOLD;
          end else begin
            state     <= ARB_RUN;
            cpu_rdy_q <= 1'b1;
          end
        end
        default: begin
          state     <= ARB_HOLD;
          cpu_rdy_q <= 1'b0;
        end
      endcase
    end
  end

  // RAM port muxing; at most one writer is selected in any cycle.
  always_comb begin
    bus.vga_gnt   = 1'b0;
    bus.ram_raddr = cpu_addr_last;
    bus.ram_waddr = bus.cpu_addr;
    bus.ram_wdata = bus.cpu_wdata;
    bus.ram_we    = 1'b0;
    pad_write     = 1'b0;
    unique case (state)
      ARB_RUN: begin
        bus.ram_raddr = bus.cpu_addr;
        bus.ram_we    = bus.cpu_we;
      end
      ARB_HOLD: begin
        if (bus.vga_req) begin
          bus.ram_raddr = bus.vga_addr;
          bus.vga_gnt   = 1'b1;
        end
        if (bus.uart_we) begin
          bus.ram_waddr = bus.uart_addr;
          bus.ram_wdata = bus.uart_wdata;
          bus.ram_we    = 1'b1;
        end else if (pad_pending) begin
          bus.ram_waddr = PERIPH_ADDR;
          bus.ram_wdata = pad_data;
          bus.ram_we    = 1'b1;
          pad_write     = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign bus.cpu_rdy        = cpu_rdy_q;
  assign bus.periph_pending = pad_pending;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: hosts a synchronous-read RAM, runs the directed
// scenarios followed by random traffic, and checks every cycle against a
// model built from the ownership rules (CPU runs only after two quiet,
// out-of-reset cycles; the cycle after the first quiet one re-presents
// the CPU's last address).
module tb_ram_arbiter;
  import easy6502_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #20 clk = ~clk;

  ram_arbiter_if bus ();

  ram_arbiter dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // System RAM: one write port, one registered read port.
  logic [7:0] mem [0:2047];
  logic [7:0] rdata;
  always @(posedge clk) begin
    if (bus.ram_we === 1'b1) mem[bus.ram_waddr] <= bus.ram_wdata;
    rdata <= mem[bus.ram_raddr];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic        chk_en = 1'b0;
  logic        r1 = 1'b1, r2 = 1'b1;     // reset seen 1 / 2 cycles ago
  logic        b1 = 1'b1, b2 = 1'b1;     // busy seen 1 / 2 cycles ago
  logic        m_pend = 1'b0;
  logic [7:0]  m_byte = 8'h00;
  logic [10:0] m_last = 11'd0;

  logic        e_rdy, e_res, e_hold, e_gnt, e_we, busy_now, pad_wr;
  logic [10:0] e_raddr, e_waddr;
  logic [7:0]  e_wdata;

  always @(negedge clk) begin
    if (chk_en) begin
      e_rdy   = !r1 && !r2 && !b1 && !b2;
      e_res   = !e_rdy && !r1 && !b1;
      e_hold  = !e_rdy && !e_res;
      e_gnt   = 1'b0;
      e_we    = 1'b0;
      e_raddr = m_last;
      e_waddr = 11'd0;
      e_wdata = 8'd0;
      pad_wr  = 1'b0;
      if (e_rdy) begin
        e_raddr = bus.cpu_addr;
        e_we    = bus.cpu_we;
        e_waddr = bus.cpu_addr;
        e_wdata = bus.cpu_wdata;
      end else if (e_hold) begin
        if (bus.vga_req) begin
          e_gnt   = 1'b1;
          e_raddr = bus.vga_addr;
        end
        if (bus.uart_we) begin
          e_we = 1'b1; e_waddr = bus.uart_addr; e_wdata = bus.uart_wdata;
        end else if (m_pend) begin
          e_we = 1'b1; e_waddr = 11'd10; e_wdata = m_byte; pad_wr = 1'b1;
        end
      end
      check("cpu_rdy", bus.cpu_rdy, e_rdy);
      check("vga_gnt", bus.vga_gnt, e_gnt);
      check("ram_raddr", bus.ram_raddr, e_raddr);
      check("ram_we", bus.ram_we, e_we);
      check("periph_pending", bus.periph_pending, m_pend);
      if (e_we) begin
        check("ram_waddr", bus.ram_waddr, e_waddr);
        check("ram_wdata", bus.ram_wdata, e_wdata);
      end
      busy_now = bus.vga_req | bus.uart_req | m_pend;
      if (reset) begin
        m_pend = 1'b0;
        m_last = 11'd0;
      end else begin
        if (bus.periph_strobe) begin
          m_pend = 1'b1;
          m_byte = bus.periph_wdata;
        end else if (pad_wr) begin
          m_pend = 1'b0;
        end
        if (e_rdy) m_last = bus.cpu_addr;
      end
      r2 = r1; r1 = reset;
      b2 = b1; b1 = busy_now;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.cpu_addr      = 11'd0;
    bus.cpu_wdata     = 8'd0;
    bus.cpu_we        = 1'b0;
    bus.vga_req       = 1'b0;
    bus.vga_addr      = 11'd0;
    bus.uart_req      = 1'b0;
    bus.uart_we       = 1'b0;
    bus.uart_addr     = 11'd0;
    bus.uart_wdata    = 8'd0;
    bus.periph_strobe = 1'b0;
    bus.periph_wdata  = 8'd0;
  endtask

  // Advance until the CPU is running again; an expired bound is a failure.
  task automatic wait_rdy(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      cyc();
      samp();
      if (bus.cpu_rdy === 1'b1) ok = 1'b1;
    end
    check(name, ok, 1'b1);
  endtask

  logic [7:0] vdat [0:7];
  int         ngot, vidx, lowcnt;
  bit         prev_gnt, seen_low, done, prev_req;

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'(i) ^ 8'h5A;
    idle_inputs();
    reset = 1'b1;
    repeat (3) cyc();

    // Reset state, then release: RDY 0,0,1.
    chk_en = 1'b1;
    samp();
    check("rst_rdy", bus.cpu_rdy, 1'b0);
    check("rst_pend", bus.periph_pending, 1'b0);
    check("rst_we", bus.ram_we, 1'b0);
    cyc(); reset = 1'b0;
    samp(); check("rel_rdy_c0", bus.cpu_rdy, 1'b0);
    cyc();
    samp(); check("rel_rdy_c1", bus.cpu_rdy, 1'b0);
    cyc();
    samp(); check("rel_rdy_c2", bus.cpu_rdy, 1'b1);

    // CPU writes, then reads 0x0FE while a 4-address VGA burst runs.
    cyc(); bus.cpu_addr = 11'h200; bus.cpu_wdata = 8'h55; bus.cpu_we = 1'b1;
    cyc(); bus.cpu_addr = 11'h0FE; bus.cpu_wdata = 8'hA7; bus.cpu_we = 1'b1;
    cyc(); bus.cpu_we = 1'b0; bus.cpu_addr = 11'h0FE;
    bus.vga_req = 1'b1; bus.vga_addr = 11'h300;
    vidx = 0; lowcnt = 0; ngot = 0; prev_gnt = 0; seen_low = 0; done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      samp();
      if (prev_gnt && ngot < 8) begin vdat[ngot] = rdata; ngot++; end
      prev_gnt = bus.vga_gnt;
      if (bus.cpu_rdy !== 1'b1) begin
        lowcnt++; seen_low = 1'b1;
      end else if (seen_low) begin
        check("resume_di", rdata, 8'hA7);
        done = 1'b1;
      end
      if (!done) begin
        cyc();
        if (prev_gnt) begin
          vidx++;
          if (vidx < 4) bus.vga_addr = 11'h300 + 11'(vidx);
          else bus.vga_req = 1'b0;
        end
      end
    end
    check("vga_resume_seen", done, 1'b1);
    check("vga_rdy_low_cycles", lowcnt, 6);
    check("vga_ngot", ngot, 4);
    check("vga_d0", vdat[0], 8'h5A);
    check("vga_d1", vdat[1], 8'h5B);
    check("vga_d2", vdat[2], 8'h58);
    check("vga_d3", vdat[3], 8'h59);
    check("cpu_wr_200", mem[11'h200], 8'h55);

    // UART burst; the CPU's stalled write to 0x7FF must never land.
    cyc(); bus.uart_req = 1'b1;
    cyc();
    bus.cpu_we = 1'b1; bus.cpu_addr = 11'h7FF; bus.cpu_wdata = 8'hEE;
    for (int i = 0; i < 16; i++) begin
      bus.uart_we = 1'b1; bus.uart_addr = 11'h600 + 11'(i); bus.uart_wdata = 8'(i);
      cyc();
    end
    bus.uart_req = 1'b0; bus.uart_we = 1'b0; bus.cpu_we = 1'b0;
    samp(); cyc();
    samp(); check("uart_drop_p1", bus.cpu_rdy, 1'b0);
    cyc();
    samp(); check("uart_drop_p2", bus.cpu_rdy, 1'b1);
    for (int i = 0; i < 16; i++) check("uart_mem", mem[11'h600 + 11'(i)], 32'(i));
    check("no_cpu_wr_in_hold", mem[11'h7FF], 8'hA5);

    // Pad byte from RUN.
    cyc(); bus.periph_strobe = 1'b1; bus.periph_wdata = 8'h3C;
    cyc(); bus.periph_strobe = 1'b0;
    samp(); check("pad_pending_set", bus.periph_pending, 1'b1);
    wait_rdy("pad_resume");
    check("pad_mem", mem[10], 8'h3C);
    check("pad_pending_clr", bus.periph_pending, 1'b0);

    // Two pad strobes during a loader burst: only the latest lands, later.
    cyc(); bus.uart_req = 1'b1;
    cyc(); bus.uart_we = 1'b1; bus.uart_addr = 11'h620; bus.uart_wdata = 8'h11;
    cyc(); bus.uart_addr = 11'h621; bus.uart_wdata = 8'h22;
    bus.periph_strobe = 1'b1; bus.periph_wdata = 8'h81;
    cyc(); bus.uart_addr = 11'h622; bus.uart_wdata = 8'h33; bus.periph_wdata = 8'h82;
    cyc(); bus.periph_strobe = 1'b0; bus.uart_addr = 11'h623; bus.uart_wdata = 8'h44;
    cyc(); bus.uart_we = 1'b0; bus.uart_req = 1'b0;
    wait_rdy("pad2_resume");
    check("pad2_u0", mem[11'h620], 8'h11);
    check("pad2_u1", mem[11'h621], 8'h22);
    check("pad2_u2", mem[11'h622], 8'h33);
    check("pad2_u3", mem[11'h623], 8'h44);
    check("pad2_mem", mem[10], 8'h82);

    // Reset during a VGA burst with a pad byte still pending.
    cyc(); bus.vga_req = 1'b1; bus.vga_addr = 11'h310; bus.uart_req = 1'b1;
    cyc(); bus.uart_we = 1'b1; bus.uart_addr = 11'h630; bus.uart_wdata = 8'h66;
    bus.periph_strobe = 1'b1; bus.periph_wdata = 8'hC3;
    cyc(); bus.periph_strobe = 1'b0; reset = 1'b1;
    samp(); check("prerst_pend", bus.periph_pending, 1'b1);
    cyc(); reset = 1'b0; bus.vga_req = 1'b0; bus.uart_req = 1'b0; bus.uart_we = 1'b0;
    samp();
    check("postrst_pend", bus.periph_pending, 1'b0);
    check("postrst_we", bus.ram_we, 1'b0);
    check("postrst_rdy", bus.cpu_rdy, 1'b0);
    wait_rdy("postrst_resume");
    check("postrst_mem10", mem[10], 8'h82);

    // Random traffic, checked cycle by cycle by the model.
    prev_req = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      cyc();
      reset             = ($urandom_range(0, 99) == 0);
      bus.cpu_addr      = 11'($urandom_range(0, 2047));
      bus.cpu_wdata     = 8'($urandom_range(0, 255));
      bus.cpu_we        = ($urandom_range(0, 3) == 0);
      bus.vga_req       = ($urandom_range(0, 3) == 0);
      bus.vga_addr      = 11'($urandom_range(0, 2047));
      if (prev_req) bus.uart_req = ($urandom_range(0, 9) != 0);
      else          bus.uart_req = ($urandom_range(0, 19) == 0);
      bus.uart_we       = prev_req && bus.uart_req && ($urandom_range(0, 1) == 1);
      bus.uart_addr     = 11'($urandom_range(0, 2047));
      bus.uart_wdata    = 8'($urandom_range(0, 255));
      bus.periph_strobe = ($urandom_range(0, 11) == 0);
      bus.periph_wdata  = 8'($urandom_range(0, 255));
      prev_req          = bus.uart_req;
    end
    cyc();
    reset = 1'b0;
    idle_inputs();
    repeat (5) cyc();
    samp();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Arbitrates the single dual-port system RAM (one write port, one synchronous read port) between the 6502 core, the VGA renderer's screen reads, the UART program loader and the pad peripheral write. It sits between those requesters and `generic_ram` in the top level and generates the CPU `RDY` signal. It stalls the CPU whenever another requester needs the RAM. Before releasing the CPU, it re-presents the CPU's last read address for one cycle so that the CPU's `DI` input is correct on the cycle it resumes.

## Interface
Parameters:
- `ADDR_WIDTH`, default 11: RAM address width.
- `DATA_WIDTH`, default 8: RAM data width.
- `PERIPH_ADDR`, default 11'd10: fixed RAM address that receives pad data.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock (25 MHz domain).
- `reset` in 1: synchronous, active-high.
- `cpu_addr` in ADDR_WIDTH: CPU address bus (`AB`) low bits.
- `cpu_wdata` in DATA_WIDTH: CPU `DO`.
- `cpu_we` in 1: CPU `WE`.
- `cpu_rdy` out 1: drives CPU `RDY`.
- `vga_req` in 1: screen read request.
- `vga_addr` in ADDR_WIDTH: screen read address.
- `vga_gnt` out 1: `vga_addr` is on `ram_raddr` this cycle.
- `uart_req` in 1: loader wants the RAM (level, held for the whole burst).
- `uart_we` in 1: loader write strobe.
- `uart_addr` in ADDR_WIDTH: loader write address.
- `uart_wdata` in DATA_WIDTH: loader write data.
- `periph_strobe` in 1: one-cycle pulse meaning new pad byte available.
- `periph_wdata` in DATA_WIDTH: pad byte, sampled on the strobe.
- `periph_pending` out 1: pad byte latched, not yet written.
- `ram_raddr` out ADDR_WIDTH: RAM read address.
- `ram_waddr` out ADDR_WIDTH: RAM write address.
- `ram_wdata` out DATA_WIDTH: RAM write data.
- `ram_we` out 1: RAM write enable.

## Operation
- State machine with three states:
  - RUN: CPU owns the RAM.
  - HOLD: CPU stalled; other requesters are served.
  - RESUME: one-cycle re-presentation of the CPU's last read address.
- `busy = vga_req | uart_req | periph_pending`.
- State transitions:
  - RUN → HOLD when `busy`.
  - HOLD → RESUME when `!busy`.
  - HOLD stays in HOLD while `busy`.
  - RESUME → HOLD if `busy`, else RESUME → RUN.
- RUN:
  - `cpu_rdy=1`, `ram_raddr=cpu_addr`, `ram_waddr=cpu_addr`, `ram_wdata=cpu_wdata`, `ram_we=cpu_we`.
  - `cpu_addr_last<=cpu_addr` every RUN cycle.
- HOLD:
  - `cpu_rdy=0`.
  - `ram_raddr=vga_addr` and `vga_gnt=1` when `vga_req`; otherwise `ram_raddr=cpu_addr_last`.
  - Write port priority: `uart_we` (uart_addr/uart_wdata) > `periph_pending` (PERIPH_ADDR/latched byte) > idle (`ram_we=0`).
- RESUME: `cpu_rdy=0`, `ram_raddr=cpu_addr_last`, `ram_we=0`, `vga_gnt=0`.
- Pad latch:
  - `periph_strobe` loads the data latch and sets `periph_pending`.
  - A pad write in HOLD clears `periph_pending`.
  - Strobe in the same cycle as the pad write: the old byte is written, the new byte is latched, and pending stays 1.
  - Strobe while already pending: the latest byte wins.
- `uart_we` outside HOLD is ignored. The loader must assert `uart_req` at least one cycle before its first `uart_we`.

## Timing
- Reset values: state=HOLD, `cpu_rdy=0`, `vga_gnt=0`, `ram_we=0`, `periph_pending=0`, `cpu_addr_last=0`.
- With no requests after reset release: HOLD, RESUME, then RUN. `cpu_rdy` rises 2 cycles after the first non-reset edge.
- Request latency is one cycle:
  - `vga_req` asserted in cycle t while in RUN → `vga_gnt` in t+1.
  - RAM data for `vga_addr` appears on the read port in t+2.
  - The VGA renderer issues `vga_req` one cycle ahead of need.
- Stall/resume:
  - `cpu_rdy` falls in the cycle after `busy` rises from RUN.
  - `cpu_rdy` is back no earlier than 2 cycles after `busy` falls.
  - In the first resumed cycle, RAM output equals data at `cpu_addr_last`.
- An accepted RUN-cycle CPU write is never dropped; a CPU write with `cpu_rdy=0` is never issued.
- `reset` mid-HOLD or mid-RESUME: next cycle is HOLD with reset values, and any pending pad byte is discarded.
- `ram_we` is asserted at most once per cycle; there are no simultaneous writers.

## Structure
- Shared package `easy6502_pkg`: state encoding (`ARB_RUN`, `ARB_HOLD`, `ARB_RESUME`), `RAM_ADDR_W=11`, and `PAD_RAM_ADDR=11'd10` (also consumed by software docs).
- One natural sub-module: `periph_latch` (strobe-captured byte plus pending flag with clear). The FSM and muxes stay in `ram_arbiter`.

## Test plan
- Reset release with no requests → `cpu_rdy` 0,0,1. CPU write 0x55 to 0x200 → RAM[0x200]=0x55.
- CPU reads 0x0FE (=0xA7); `vga_req` pulsed 4 cycles at 0x300..0x303 → VGA gets RAM[0x300..0x303] in order. First CPU cycle after resume sees DI=0xA7, and `cpu_rdy` is low for exactly 6 cycles.
- `uart_req` high, then writes 0x00..0x0F to 0x600..0x60F, then drop → RAM holds the bytes. No CPU write occurs during the burst; `cpu_rdy` returns 2 cycles after drop.
- `periph_strobe` with 0x3C while in RUN → `periph_pending`=1, one HOLD write RAM[10]=0x3C, pending clears, CPU resumes.
- `periph_strobe` with 0x81 while `uart_we` is active, then 0x82 one cycle later → UART writes are unaffected and RAM[10]=0x82 after `uart_req` drops.
- Reset asserted during a VGA burst with pad pending → state HOLD, `periph_pending`=0, `ram_we`=0 next cycle, and RAM[10] is unchanged.
